// File: rtl/freq_meas.sv
// Measures period and high time of a slow clock sampled as data in the clk domain.
// Also raises lock after LOCK_N consecutive periods equal exp_period, and pulses timeout when edges stop.
module freq_meas #(
  parameter int CNT_W  = 5,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_clk,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_len,
  output logic             valid,
  output logic             lock,
  output logic             timeout
);

  localparam int                 MATCH_W   = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  logic               s1, s2, s3;
  logic               rise_p1, fall_p1;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   hi_tmp;
  logic [MATCH_W-1:0] match;

  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v);
    return (v >= MATCH_MAX) ? v : v + MATCH_W'(1);
  endfunction

  // Stage p0: synchronizer and delay flop; stage p1: registered edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      s1      <= in_clk;
      s2      <= s1;
      s3      <= s2;
      rise_p1 <= s2 & ~s3;
      fall_p1 <= ~s2 & s3;
    end
  end

  // Stage p2: measurement FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_tmp   <= '0;
      match    <= '0;
      period   <= '0;
      high_len <= '0;
      valid    <= 1'b0;
      lock     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      lock    <= (match == MATCH_MAX);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise_p1) begin
            state <= MEAS_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        MEAS_HIGH: begin
          // A second rise without a fall, or no edge before saturation, aborts
          if (rise_p1 || cnt == CNT_MAX) begin
            timeout <= 1'b1;
            lock    <= 1'b0;
            match   <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fall_p1) begin
              hi_tmp <= cnt;
              state  <= MEAS_LOW;
            end
          end
        end
        MEAS_LOW: begin
          if (rise_p1) begin
            period   <= cnt;
            high_len <= hi_tmp;
            valid    <= 1'b1;
            cnt      <= CNT_W'(1);
            state    <= MEAS_HIGH;
            if (exp_period != '0 && cnt == exp_period) match <= sat_inc(match);
            else                                        match <= '0;
          end else if (cnt == CNT_MAX) begin
            timeout <= 1'b1;
            lock    <= 1'b0;
            match   <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_meas.md
FREQ_MEAS -- requirements
Module: freq_meas

Interface
REQ-001 Parameter: CNT_W, default 5, width of the period and high-time counters and outputs.
REQ-002 Parameter: LOCK_N, default 4, number of consecutive matching periods required to assert lock.
REQ-003 Port: clk  input  1  reference clock; every register is clocked on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: in_clk  input  1  divided clock under measurement, treated as data and sampled by clk.
REQ-006 Port: exp_period  input  CNT_W  expected period of in_clk in clk cycles; 0 disables matching.
REQ-007 Port: period  output  CNT_W  last measured period (rising edge to rising edge) in clk cycles.
REQ-008 Port: high_len  output  CNT_W  last measured high time (rising edge to falling edge) in clk cycles.
REQ-009 Port: valid  output  1  one-cycle pulse when period/high_len are updated.
REQ-010 Port: lock  output  1  asserted while the last LOCK_N measured periods all equal exp_period.
REQ-011 Port: timeout  output  1  one-cycle pulse when no edge arrives before the counter saturates.

Function
REQ-012 in_clk SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 FSM states SHALL be IDLE, MEAS_HIGH and MEAS_LOW.
REQ-014 IDLE: counter held at 0; on rise -> MEAS_HIGH with counter loaded to 1; no valid pulse.
REQ-015 MEAS_HIGH: counter +1 per cycle; on fall, hi_tmp <= counter and the FSM SHALL go to MEAS_LOW while the counter keeps running.
REQ-016 MEAS_LOW: counter +1 per cycle; on rise, period <= counter, high_len <= hi_tmp, valid = 1 for that cycle, counter reloads to 1, and the FSM SHALL go to MEAS_HIGH.
REQ-017 A rise seen in MEAS_HIGH (no fall in between, impossible when synchronized) SHALL be treated as a timeout.
REQ-018 When the counter reaches 2^CNT_W-1 without the awaited edge, timeout = 1 for one cycle, lock = 0, match count cleared, state -> IDLE; period and high_len SHALL hold their values.
REQ-019 Match counter (width ceil(log2(LOCK_N+1))): on each valid, +1 saturating at LOCK_N if period == exp_period and exp_period != 0, otherwise cleared to 0.
REQ-020 lock SHALL be registered, equal (match count == LOCK_N), and update the cycle after valid.
REQ-021 A change of exp_period SHALL take effect at the next valid with no other side effect.
REQ-022 Latency: valid SHALL assert 3 clk cycles after the in_clk rising edge is first sampled high by s1 (the s1 -> s2 -> detect -> register path).
REQ-023 in_clk stuck at constant level SHALL never produce valid; it produces timeout once, then waits in IDLE.

Reset
REQ-024 While reset = 1: state = IDLE, counter/hi_tmp/match = 0, period = 0, high_len = 0, valid = 0, lock = 0, timeout = 0, s1..s3 = 0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial measurement; after release the first valid SHALL need one full rise-to-rise interval.

Verification
REQ-026 in_clk = clk/4 (2 high, 2 low), exp_period = 4 -> first valid 4 cycles after the second rise; period = 4, high_len = 2; lock rises after 4 valids.
REQ-027 in_clk = clk/10 (5 high, 5 low), exp_period = 8 -> period = 10, high_len = 5 each valid; lock stays 0.
REQ-028 Locked at /6, then switch to /7 -> first period = 7 valid, lock drops the next cycle, re-locks after 4 more valids if exp_period = 7.
REQ-029 in_clk held low after locking, CNT_W = 5 -> exactly one timeout pulse when the counter hits 31; lock = 0; state IDLE; period holds 6.
REQ-030 Reset pulsed in MEAS_LOW during /8 -> all outputs 0 next cycle; no valid until two rises after release; then period = 8.
REQ-031 exp_period = 0 with a steady /4 input -> valid every 4 cycles, lock never asserts.
